// File: rtl/regfile_sb.sv
// regfile_sb: 8-entry register file with two registered read ports, one
// write-back port and a per-register scoreboard of pending writes.
//
// Ports:
//   clk, rst_n             clock, synchronous active-low reset
//   rd_en, rd_addr_a/b     read request; both ports are captured together
//   rd_data_a/b            registered read data (1-cycle latency, held when idle)
//   wr_en, wr_addr, wr_data  write-back port; also clears busy_vec[wr_addr]
//   iss_en, iss_dest       issue; sets busy_vec[iss_dest] unless stalled
//   stall                  combinational hazard: a read source is still pending
//   busy_vec               registered scoreboard, bit i = register i pending
//
// Register 0 is hard-wired to zero and is never marked busy.
//
// Optional feature macro: REGFILE_BYPASS_EN
//   defined   : a same-cycle write to a nonzero read address forwards wr_data
//               to that read port, and stall ignores a busy bit that this
//               cycle's write is clearing.
//   undefined : reads return the old register value; stall uses busy_vec as is.
module regfile_sb #(
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [2:0]        rd_addr_a,
  input  logic [2:0]        rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [2:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [2:0]        iss_dest,
  output logic              stall,
  output logic [7:0]        busy_vec
);
  localparam int NREG = 8;

  logic [NREG-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]           rd_data_a_q, rd_data_a_d;
  logic [DATA_W-1:0]           rd_data_b_q, rd_data_b_d;
  logic [NREG-1:0]             busy_vec_q, busy_vec_d;
  logic [NREG-1:0]             busy_eff;
  logic [DATA_W-1:0]           rv_a, rv_b;

  // Register array update; entry 0 is never written so it stays zero.
  always_comb begin
    regs_d = regs_q;
    if (wr_en && wr_addr != 3'd0) regs_d[wr_addr] = wr_data;
  end

  // Read values as seen this cycle, with optional write forwarding.
  always_comb begin
    rv_a = (rd_addr_a == 3'd0) ? '0 : regs_q[rd_addr_a];
    rv_b = (rd_addr_b == 3'd0) ? '0 : regs_q[rd_addr_b];
`ifdef REGFILE_BYPASS_EN
    if (wr_en && wr_addr != 3'd0 && wr_addr == rd_addr_a) rv_a = wr_data;
    if (wr_en && wr_addr != 3'd0 && wr_addr == rd_addr_b) rv_b = wr_data;
`endif
    rd_data_a_d = rd_data_a_q;
    rd_data_b_d = rd_data_b_q;
    if (rd_en) begin
      rd_data_a_d = rv_a;
      rd_data_b_d = rv_b;
    end
  end

  // Hazard detect and scoreboard next state.
  always_comb begin
    busy_eff = busy_vec_q;
`ifdef REGFILE_BYPASS_EN
    // The pending write lands this cycle and is forwarded, so no hazard.
    if (wr_en) busy_eff[wr_addr] = 1'b0;
`endif
    stall = rd_en & (busy_eff[rd_addr_a] | busy_eff[rd_addr_b]);

    busy_vec_d = busy_vec_q;
    if (wr_en) busy_vec_d[wr_addr] = 1'b0;
    // Set after clear so a same-register issue wins over the write-back.
    if (iss_en && !stall && iss_dest != 3'd0) busy_vec_d[iss_dest] = 1'b1;
    busy_vec_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q      <= '0;
      rd_data_a_q <= '0;
      rd_data_b_q <= '0;
      busy_vec_q  <= '0;
    end else begin
      regs_q      <= regs_d;
      rd_data_a_q <= rd_data_a_d;
      rd_data_b_q <= rd_data_b_d;
      busy_vec_q  <= busy_vec_d;
    end
  end

  assign rd_data_a = rd_data_a_q;
  assign rd_data_b = rd_data_b_q;
  assign busy_vec  = busy_vec_q;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed testbench for regfile_sb. Inputs change 1 time unit after a
// rising edge; stall is sampled just before the next edge, registered
// outputs 1 time unit after it.
module tb_regfile_sb;
  localparam int DATA_W = 64;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rd_en;
  logic [2:0]        rd_addr_a, rd_addr_b;
  logic [DATA_W-1:0] rd_data_a, rd_data_b;
  logic              wr_en;
  logic [2:0]        wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              iss_en;
  logic [2:0]        iss_dest;
  logic              stall;
  logic [7:0]        busy_vec;

  int checks = 0;
  int fails  = 0;

  regfile_sb #(.DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_dest(iss_dest),
    .stall(stall), .busy_vec(busy_vec)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle();
    rd_en = 0; rd_addr_a = 0; rd_addr_b = 0;
    wr_en = 0; wr_addr = 0; wr_data = '0;
    iss_en = 0; iss_dest = 0;
  endtask

  // Advance one edge; leave the bench 1 unit past it.
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [63:0] d);
    idle(); wr_en = 1; wr_addr = a; wr_data = d; step();
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    idle(); rd_en = 1; rd_addr_a = a; rd_addr_b = b; step();
  endtask

  task automatic iss(input logic [2:0] d);
    idle(); iss_en = 1; iss_dest = d; step();
  endtask

  initial begin
    idle();
    rst_n = 0;
    step(); step();
    rst_n = 1;
    chk("rst_busy", {56'd0, busy_vec}, 64'h0);
    chk("rst_rda", rd_data_a, 64'h0);
    chk("rst_stall", {63'd0, stall}, 64'h0);

    // Read after reset
    rd(3'd3, 3'd5);
    chk("r33_a", rd_data_a, 64'h0);
    chk("r33_b", rd_data_b, 64'h0);
    chk("r33_busy", {56'd0, busy_vec}, 64'h0);

    // Write then read back; r0 is hard zero
    wr(3'd3, 64'hDEAD_BEEF);
    rd(3'd3, 3'd5);
    chk("r34_a", rd_data_a, 64'hDEAD_BEEF);
    chk("r34_b", rd_data_b, 64'h0);
    wr(3'd0, 64'd5);
    rd(3'd0, 3'd3);
    chk("r0_a", rd_data_a, 64'h0);
    chk("r0_b", rd_data_b, 64'hDEAD_BEEF);

    // rd_en low holds outputs
    idle(); rd_addr_a = 3'd3; rd_addr_b = 3'd3; step();
    chk("hold_a", rd_data_a, 64'h0);
    chk("hold_b", rd_data_b, 64'hDEAD_BEEF);

    // Read-during-write same address
    wr(3'd4, 64'h22);
    idle(); wr_en = 1; wr_addr = 3'd4; wr_data = 64'h11;
    rd_en = 1; rd_addr_a = 3'd4; rd_addr_b = 3'd2; step();
    chk("rdw_a", rd_data_a, BYP ? 64'h11 : 64'h22);
    rd(3'd4, 3'd4);
    chk("rdw_after", rd_data_a, 64'h11);

    // Issue / stall / write-back clear
    iss(3'd6);
    chk("iss6_busy", {56'd0, busy_vec}, 64'h40);
    idle(); rd_en = 1; rd_addr_a = 3'd6; iss_en = 1; iss_dest = 3'd5;
    #3; chk("stall6", {63'd0, stall}, 64'h1);
    step();
    chk("iss_stalled_ign", {56'd0, busy_vec}, 64'h40);
    idle(); rd_en = 1; rd_addr_a = 3'd6; wr_en = 1; wr_addr = 3'd6; wr_data = 64'h66;
    #3; chk("stall6_wb", {63'd0, stall}, BYP ? 64'h0 : 64'h1);
    step();
    chk("wb6_busy", {56'd0, busy_vec}, 64'h0);
    chk("wb6_rda", rd_data_a, BYP ? 64'h66 : 64'h0);
    idle(); rd_en = 1; rd_addr_a = 3'd6;
    #3; chk("stall6_clr", {63'd0, stall}, 64'h0);
    step();
    chk("rd6", rd_data_a, 64'h66);

    // Set wins over clear on same register
    iss(3'd2);
    chk("iss2", {56'd0, busy_vec}, 64'h04);
    idle(); iss_en = 1; iss_dest = 3'd2; wr_en = 1; wr_addr = 3'd2; wr_data = 64'h77; step();
    chk("setwins", {56'd0, busy_vec}, 64'h04);
    // Set and clear different registers
    idle(); iss_en = 1; iss_dest = 3'd3; wr_en = 1; wr_addr = 3'd2; wr_data = 64'h78; step();
    chk("setclr_diff", {56'd0, busy_vec}, 64'h08);
    wr(3'd3, 64'h33);
    chk("clr3", {56'd0, busy_vec}, 64'h0);
    iss(3'd0);
    chk("iss0", {56'd0, busy_vec}, 64'h0);
    // Write to non-busy register still writes
    rd(3'd2, 3'd3);
    chk("nb_wr_a", rd_data_a, 64'h78);
    chk("nb_wr_b", rd_data_b, 64'h33);

    // Reset mid-operation discards scoreboard and ignores requests
    for (int i = 1; i <= 6; i++) iss(3'(i));
    chk("busy7e", {56'd0, busy_vec}, 64'h7E);
    idle(); rst_n = 0; wr_en = 1; wr_addr = 3'd1; wr_data = 64'd9;
    iss_en = 1; iss_dest = 3'd7; rd_en = 1; rd_addr_a = 3'd2; step();
    rst_n = 1; idle();
    chk("mrst_busy", {56'd0, busy_vec}, 64'h0);
    chk("mrst_rda", rd_data_a, 64'h0);
    chk("mrst_stall", {63'd0, stall}, 64'h0);
    rd(3'd1, 3'd2);
    chk("mrst_r1", rd_data_a, 64'h0);
    chk("mrst_r2", rd_data_b, 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
